// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: shared processor-side definitions for the
// switch-input front end (data width, debounce state encoding).
package input_debouncer_pkg;

  localparam int DATA_W = 16;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_SETTLE = 1'b1;

  typedef enum logic {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE
  } deb_state_e;

  localparam logic [7:0] CHG_MAX = 8'hFF;

  // Counter width for a 0..v-1 counter, never narrower than 1 bit.
  function automatic int min1_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// sync_chain: plain flop chain bringing an async bus into clk.
// Ports: clk, reset (async, high), d (async in), q (synchronised out).
module sync_chain
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++)
        ff[i] <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++)
        ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronise + whole-word debounce of the switch bus.
// Ports: clk, reset (async, high), raw_in, data_out, stable, changed,
// change_count (only with INPUT_DEBOUNCE_CHANGE_COUNT_EN defined).
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH           = DATA_W,
  parameter int SYNC_STAGES     = 2,
  parameter int PRESCALE        = 1000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] data_out,
  output logic             stable,
  output logic             changed
`ifdef INPUT_DEBOUNCE_CHANGE_COUNT_EN
  ,
  output logic [7:0]       change_count
`endif
);

  localparam int PW = min1_clog2(PRESCALE);
  localparam int CW = min1_clog2(DEBOUNCE_CYCLES);

  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (raw_in),
    .q     (sync_q)
  );

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == P_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pcnt <= '0;
    else if (tick)
      pcnt <= '0;
    else
      pcnt <= pcnt + PW'(1);
  end

  deb_state_e       state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             chg_d;

  // Any new sampled word restarts the window, whatever the state,
  // so a bouncing switch keeps pushing the commit out.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    data_d  = data_out;
    chg_d   = 1'b0;
    if (tick) begin
      if (sync_q != cand_q) begin
        cand_d  = sync_q;
        cnt_d   = '0;
        state_d = SETTLE;
      end else begin
        unique case (state_q)
          SETTLE: begin
            if (cnt_q == C_LAST) begin
              data_d  = cand_q;
              state_d = IDLE;
              chg_d   = (cand_q != data_out);
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          IDLE: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      data_out <= '0;
      changed  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      data_out <= data_d;
      changed  <= chg_d;
    end
  end

  assign stable = (state_q == IDLE);

`ifdef INPUT_DEBOUNCE_CHANGE_COUNT_EN
  logic [7:0] cc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cc_q <= '0;
    else if (chg_d && (cc_q != CHG_MAX))
      cc_q <= cc_q + 8'd1;
  end

  assign change_count = cc_q;
`endif

endmodule
